// File: rtl/exception_ctrl.sv
// Exception sequencer: saves the faulting PC and cause, fetches the handler
// vector byte from memory and strobes it into the PC.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   pc_in            current PC (already +4)
//   exc_opcode       invalid-opcode request (highest priority)
//   exc_overflow     ALU overflow request
//   exc_divzero      divide-by-zero request (lowest priority)
//   mem_byte         low byte of memory read data
//   epc_out          saved exception PC (pc_in - 4)
//   exc_addr         vector byte address (253/254/255) while reading
//   exc_addr_sel     block owns the memory address
//   pc_vector        handler address, valid with pc_load
//   pc_load          one-cycle PC load strobe
//   busy             sequence in progress, core stalls
//   cause            latched cause code
module exception_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_divzero,
    input  logic [7:0]  mem_byte,
    output logic [31:0] epc_out,
    output logic [31:0] exc_addr,
    output logic        exc_addr_sel,
    output logic [31:0] pc_vector,
    output logic        pc_load,
    output logic        busy,
    output logic [1:0]  cause
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        LOAD = 2'd3
    } state_t;

    state_t     state;
    logic [1:0] new_cause;
    logic       exc_any;

    always_comb begin
        new_cause = 2'b00;
        if (exc_opcode)
            new_cause = 2'b01;
        else if (exc_overflow)
            new_cause = 2'b10;
        else if (exc_divzero)
            new_cause = 2'b11;
    end

    assign exc_any = exc_opcode | exc_overflow | exc_divzero;

    // Vector addresses 253..255 are 252 + cause, so the address is
    // derived directly from the cause code being latched.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            epc_out      <= 32'h0;
            cause        <= 2'b00;
            exc_addr     <= 32'h0;
            exc_addr_sel <= 1'b0;
            pc_load      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (exc_any) begin
                        state        <= READ;
                        epc_out      <= pc_in - 32'd4;
                        cause        <= new_cause;
                        exc_addr     <= 32'd252 + {30'd0, new_cause};
                        exc_addr_sel <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                READ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    state        <= LOAD;
                    exc_addr     <= 32'h0;
                    exc_addr_sel <= 1'b0;
                    pc_load      <= 1'b1;
                end
                LOAD: begin
                    state   <= IDLE;
                    pc_load <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory data arrives during LOAD, so the vector is passed straight
    // through and gated by the strobe.
    assign pc_vector = pc_load ? {24'h000000, mem_byte} : 32'h0;

endmodule
